// File: rtl/add_ctrl_pkg.sv
// Shared types and constants for the nibble-serial multiword adder controller.
package add_ctrl_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add4_cell.sv
// 4-bit combinational ripple adder; c3 exposes the carry into bit 3 for overflow detection.
module add4_cell (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       ci,
    output logic [3:0] s4,
    output logic       co,
    output logic       c3
);

    logic [3:0] low;
    logic [1:0] top;

    always_comb begin
        low   = {1'b0, a4[2:0]} + {1'b0, b4[2:0]} + {3'b000, ci};
        c3    = low[3];
        top   = {1'b0, a4[3]} + {1'b0, b4[3]} + {1'b0, c3};
        s4    = {top[0], low[2:0]};
        co    = top[1];
    end

endmodule

// File: rtl/multiword_add_ctrl.sv
// Sequences one shared add4_cell over NIBBLES nibbles, LSB first, with valid/ready handshakes.
// Optional macro ADD_SUB_EN enables subtraction (a - b) when sub is high at acceptance.
module multiword_add_ctrl
    import add_ctrl_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                        cin,
    input  logic                        sub,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                        carry,
    output logic                        ovf,
    output logic                        busy
);

    localparam int unsigned W  = NIBBLE_W * NIBBLES;
    localparam int unsigned IW = $clog2(NIBBLES) + 1;

    state_e                state_q;
    logic [IW-1:0]         idx_q;
    logic [W-1:0]          a_q;
    logic [W-1:0]          b_q;
    logic                  chain_q;
    logic [W-1:0]          sum_q;
    logic                  carry_q;
    logic                  ovf_q;
    logic                  out_valid_q;
    logic                  busy_q;
    logic                  in_ready_q;

    logic [W-1:0]          b_d;
    logic                  seed_d;
    logic [NIBBLE_W-1:0]   a_nib;
    logic [NIBBLE_W-1:0]   b_nib;
    logic [NIBBLE_W-1:0]   s_nib;
    logic                  co_nib;
    logic                  c3_nib;
    logic                  last_nib;

`ifdef ADD_SUB_EN
    // Subtraction is a + ~b + 1; carry out of 1 then means no borrow.
    always_comb begin
        b_d    = sub ? ~b : b;
        seed_d = sub ? 1'b1 : cin;
    end
`else
    logic unused_sub;
    assign unused_sub = sub;

    always_comb begin
        b_d    = b;
        seed_d = cin;
    end
`endif

    always_comb begin
        a_nib = '0;
        b_nib = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IW'(i)) begin
                a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
                b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
            end
        end
        last_nib = (idx_q == IW'(NIBBLES - 1));
    end

    add4_cell u_add4_cell (
        .a4 (a_nib),
        .b4 (b_nib),
        .ci (chain_q),
        .s4 (s_nib),
        .co (co_nib),
        .c3 (c3_nib)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            chain_q     <= 1'b0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b_d;
                        chain_q    <= seed_d;
                        idx_q      <= '0;
                        sum_q      <= '0;
                        carry_q    <= 1'b0;
                        ovf_q      <= 1'b0;
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    for (int i = 0; i < NIBBLES; i++) begin
                        if (idx_q == IW'(i)) begin
                            sum_q[i*NIBBLE_W +: NIBBLE_W] <= s_nib;
                        end
                    end
                    chain_q <= co_nib;
                    if (last_nib) begin
                        carry_q     <= co_nib;
                        ovf_q       <= c3_nib ^ co_nib;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DONE: begin
                    // in_ready rises only after this edge, giving the one-cycle idle bubble.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    busy_q     <= 1'b0;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_multiword_add_ctrl.sv
// Self-checking bench for multiword_add_ctrl (NIBBLES=4): directed cases plus random ops vs a model.
module tb_multiword_add_ctrl;

    localparam int unsigned N = 4;
    localparam int unsigned W = 4 * N;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         ovf;
    logic         busy;

    int vectors    = 0;
    int miscompares = 0;

    multiword_add_ctrl #(.NIBBLES(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole word; returns {ovf, carry, sum}.
    function automatic logic [W+1:0] ref_add(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                             input logic rcin, input logic rsub);
        logic [W-1:0] bb;
        logic         seed;
        logic [W:0]   full;
        logic         v;
        bb   = rb;
        seed = rcin;
`ifdef ADD_SUB_EN
        if (rsub) begin
            bb   = ~rb;
            seed = 1'b1;
        end
`else
        if (rsub) seed = rcin;
`endif
        full = {1'b0, ra} + {1'b0, bb} + {{W{1'b0}}, seed};
        v    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
        return {v, full[W], full[W-1:0]};
    endfunction

    task automatic start_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tcin,
                            input logic tsub);
        int waited;
        @(negedge clk);
        a        = ta;
        b        = tb;
        cin      = tcin;
        sub      = tsub;
        in_valid = 1'b1;
        waited   = 0;
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) check_eq("accept_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_result(input string tag, input logic [W+1:0] exp, input int hold);
        int lat;
        logic [W-1:0] first_sum;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 40);
        check_eq({tag, "_latency"}, lat, N + 1);
        check_eq({tag, "_sum"}, sum, exp[W-1:0]);
        check_eq({tag, "_carry"}, carry, exp[W]);
        check_eq({tag, "_ovf"}, ovf, exp[W+1]);
        first_sum = sum;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check_eq({tag, "_hold_valid"}, out_valid, 1'b1);
            check_eq({tag, "_hold_sum"}, sum, first_sum);
            check_eq({tag, "_hold_ready"}, in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        logic         rc, rs;
        int           pulses;

        rst       = 1'b1;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_eq("rst_in_ready", in_ready, 1'b1);
        check_eq("rst_out_valid", out_valid, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_sum", sum, '0);
        check_eq("rst_carry", carry, 1'b0);
        check_eq("rst_ovf", ovf, 1'b0);

        // Directed cases.
        start_op(16'h1234, 16'h0001, 1'b0, 1'b0);
        check_eq("t1_busy", busy, 1'b1);
        wait_result("t1", {1'b0, 1'b0, 16'h1235}, 0);
        start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
        wait_result("t2", {1'b0, 1'b1, 16'h0000}, 0);
        start_op(16'h7FFF, 16'h0000, 1'b1, 1'b0);
        wait_result("t3", {1'b1, 1'b0, 16'h8000}, 0);

        // Back-pressure with a new command held on the input the whole time.
        start_op(16'hA5A5, 16'h1111, 1'b0, 1'b0);
        a        = 16'h0F0F;
        b        = 16'h0101;
        cin      = 1'b1;
        in_valid = 1'b1;
        wait_result("t4a", ref_add(16'hA5A5, 16'h1111, 1'b0, 1'b0), 10);
        @(negedge clk);
        check_eq("t4_bubble_ready", in_ready, 1'b1);
        check_eq("t4_bubble_busy", busy, 1'b0);
        check_eq("t4_bubble_valid", out_valid, 1'b0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_result("t4b", ref_add(16'h0F0F, 16'h0101, 1'b1, 1'b0), 0);

        // Reset during the second RUN cycle.
        start_op(16'h4321, 16'h1111, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_eq("t5_busy", busy, 1'b0);
        check_eq("t5_out_valid", out_valid, 1'b0);
        check_eq("t5_sum", sum, '0);
        check_eq("t5_in_ready", in_ready, 1'b1);
        rst    = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check_eq("t5_no_result", pulses, 0);

`ifdef ADD_SUB_EN
        start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
        wait_result("t6a", {1'b0, 1'b0, 16'hFFFE}, 0);
        start_op(16'h8000, 16'h0001, 1'b1, 1'b1);
        wait_result("t6b", {1'b1, 1'b1, 16'h7FFF}, 0);
`endif

        // Random operations with random back-pressure.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            start_op(ra, rb, rc, rs);
            wait_result("rnd", ref_add(ra, rb, rc, rs), int'($urandom_range(0, 3)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
